mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage sitting between the EX stage and the WB stage. Holds one instruction in a stage register. Waits for the data-SRAM response of any request EX issued on its behalf, then aligns and sign/zero-extends load data. Forwards the result, exception bus and CSR side-band to WB, and drops stale responses after a pipeline flush.

## Interface
- `SIDE_W`, default 97: width of the opaque side-band (`csr_ctrl`, `res_from_csr`, `ertn`, `pause_int_detect`), passed through untouched.
- `DROP_W`, default 2: width of the stale-response drop counter.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `ex_to_mem_valid` in 1: EX holds a valid instruction ready to move.
- `mem_allow_in` out 1: MEM accepts this cycle.
- `ex_pc` in 32: instruction PC.
- `ex_result` in 32: ALU result, which is the data address for memory ops.
- `ex_rf_we` in 1, `ex_rf_waddr` in 5: register-file write intent.
- `ex_mem_op` in 3: 000 ld.b, 001 ld.h, 010 ld.w, 100 ld.bu, 101 ld.hu, 011 store, 111 none.
- `ex_req_sent` in 1: EX issued a data-SRAM request for this instruction.
- `ex_ebus` in 16: exception one-hot bus.
- `ex_side` in SIDE_W: side-band.
- `data_sram_data_ok` in 1, `data_sram_rdata` in 32: data response.
- `wb_flush` in 1: exception or ertn taken in WB.
- `mem_to_wb_valid` out 1, `wb_allow_in` in 1: downstream handshake.
- `mem_pc` out 32.
- `mem_final_result` out 32.
- `mem_rf_we` out 1, `mem_rf_waddr` out 5.
- `mem_ebus` out 16.
- `mem_side` out SIDE_W.
- `mem_has_ex` out 1: valid and (`ebus`≠0 or ertn bit), so EX suppresses stores.
- `mem_bypass_bus` out 39: {blocking, rf_we, waddr, wdata}.

## Operation
- `mem_allow_in = !valid | (ready_go & wb_allow_in)`.
- Stage register loads on `ex_to_mem_valid & mem_allow_in`.
- `valid` clears when the instruction leaves without a replacement, or on `wb_flush`. Flush has priority over load.
- `need_resp = ex_req_sent & (ebus==0)`, latched at load.

State machine:
- IDLE: no response outstanding. Loading with `need_resp` moves to WAIT; otherwise stay.
- WAIT: when `data_ok & drop_cnt==0`:
  - with `wb_allow_in`, the instruction leaves; go to IDLE, or stay in WAIT if a new `need_resp` instruction loads the same cycle;
  - otherwise latch rdata into `rdata_q` and go to HOLD.
- HOLD: leave on `wb_allow_in`, then IDLE or WAIT per the next instruction.
- `ready_go = !need_resp | HOLD | (WAIT & data_ok & drop_cnt==0)`.

Stale responses:
- `wb_flush` while in WAIT: `drop_cnt` +1, go to IDLE, `valid` 0.
- `data_ok` while `drop_cnt`≠0: `drop_cnt` −1; the data is discarded and never counts for the current instruction.
- Simultaneous flush increment and drop decrement leave `drop_cnt` unchanged.
- `drop_cnt` saturates at its maximum, which is an assertion error.

Load data:
- Select lane by `ex_result[1:0]`:
  - byte uses `rdata >> (8*a[1:0])`;
  - half uses `a[1]`.
- ld.b and ld.h sign-extend; ld.bu and ld.hu zero-extend; ld.w passes through.
- Non-load ops output `ex_result`.
- The data source is live `rdata` in WAIT and `rdata_q` in HOLD.

Other outputs:
- `mem_rf_we = rf_we & valid & (ebus==0)`.
- Bypass `blocking = valid & need_resp & !ready_go` (load data not yet present); `wdata` = `mem_final_result`.

## Timing
- Zero-latency pass-through when `need_resp`=0: loaded at edge N, `mem_to_wb_valid` during cycle N.
- A load is visible to WB in the same cycle `data_ok` is high; there is no extra cycle.
- Reset values: `valid` 0, state IDLE, `drop_cnt` 0, `rdata_q` 0, all stage fields 0. Hence every output is 0 and `mem_allow_in` is 1.
- Reset mid-WAIT clears everything, including `drop_cnt`. The SRAM is reset together with MEM.

## Configuration
- `MEM_BYPASS_EN` defined: `mem_bypass_bus` is driven as above.
- Not defined: `mem_bypass_bus` is tied to 0, and ID must interlock on MEM by other means. No other behaviour changes.

## Structure
- Shared package/header:
  - `mem_op` encodings;
  - `ebus` bit indices;
  - IDLE/WAIT/HOLD state encoding;
  - bypass bus layout constants.
- One sub-module, `load_align`: combinational lane select and extension (`mem_op`, `addr[1:0]`, `rdata` → 32-bit result).

## Test plan
- ALU op, `wb_allow_in`=1 → output in the load cycle, `mem_rf_we`=1, `mem_allow_in` stays 1.
- ld.b at addr 0x…3, rdata 0x80FF_0011, `data_ok` 2 cycles later → `ready_go` 0 for 2 cycles, result 0xFFFF_FF80, bypass `blocking` 1 meanwhile.
- ld.hu at addr 0x…2, rdata 0xBEEF_1234, `data_ok` while `wb_allow_in`=0 → HOLD; result 0x0000_BEEF held until `wb_allow_in`.
- `wb_flush` while in WAIT, then `data_ok` 3 cycles later, then a new ld.w and its `data_ok` → first response dropped (`drop_cnt` 1→0), ld.w gets the second rdata.
- `ebus`[ALE] set with `ex_req_sent`=0 → no wait, `mem_has_ex`=1, `mem_rf_we`=0.
- `resetn` low while in WAIT with `drop_cnt`=1 → all outputs 0, `mem_allow_in`=1, `drop_cnt`=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: memory-op encodings, exception
// bus bit positions, response-tracking states and the bypass bus layout.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    OP_LD_B  = 3'b000,
    OP_LD_H  = 3'b001,
    OP_LD_W  = 3'b010,
    OP_STORE = 3'b011,
    OP_LD_BU = 3'b100,
    OP_LD_HU = 3'b101,
    OP_NONE  = 3'b111
  } mem_op_e;

  localparam int EBUS_W    = 16;
  localparam int EBUS_INT  = 0;
  localparam int EBUS_ADEF = 1;
  localparam int EBUS_SYS  = 2;
  localparam int EBUS_BRK  = 3;
  localparam int EBUS_INE  = 4;
  localparam int EBUS_ALE  = 5;
  localparam int EBUS_ADEM = 6;

  // Side-band is {csr_ctrl, res_from_csr, ertn, pause_int_detect}
  localparam int SIDE_ERTN_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } mem_state_e;

  localparam int BYP_W         = 39;
  localparam int BYP_BLOCK_BIT = 38;
  localparam int BYP_WE_BIT    = 37;
  localparam int BYP_WADDR_LSB = 32;
  localparam int BYP_WDATA_LSB = 0;

  function automatic logic is_load(logic [2:0] op);
    return (op == OP_LD_B) || (op == OP_LD_H) || (op == OP_LD_W) ||
           (op == OP_LD_BU) || (op == OP_LD_HU);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the EX->MEM, data-SRAM response, flush and MEM->WB signals.
// The environment side uses the master modport, the MEM stage the slave modport.
interface mem_stage_if #(
  parameter int SIDE_W = 97
);
  import mem_stage_pkg::*;

  logic              ex_to_mem_valid;
  logic              mem_allow_in;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_result;
  logic              ex_rf_we;
  logic [4:0]        ex_rf_waddr;
  logic [2:0]        ex_mem_op;
  logic              ex_req_sent;
  logic [EBUS_W-1:0] ex_ebus;
  logic [SIDE_W-1:0] ex_side;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              wb_flush;
  logic              mem_to_wb_valid;
  logic              wb_allow_in;
  logic [31:0]       mem_pc;
  logic [31:0]       mem_final_result;
  logic              mem_rf_we;
  logic [4:0]        mem_rf_waddr;
  logic [EBUS_W-1:0] mem_ebus;
  logic [SIDE_W-1:0] mem_side;
  logic              mem_has_ex;
  logic [BYP_W-1:0]  mem_bypass_bus;

  modport master (
    output ex_to_mem_valid, ex_pc, ex_result, ex_rf_we, ex_rf_waddr, ex_mem_op,
           ex_req_sent, ex_ebus, ex_side, data_sram_data_ok, data_sram_rdata,
           wb_flush, wb_allow_in,
    input  mem_allow_in, mem_to_wb_valid, mem_pc, mem_final_result, mem_rf_we,
           mem_rf_waddr, mem_ebus, mem_side, mem_has_ex, mem_bypass_bus
  );

  modport slave (
    input  ex_to_mem_valid, ex_pc, ex_result, ex_rf_we, ex_rf_waddr, ex_mem_op,
           ex_req_sent, ex_ebus, ex_side, data_sram_data_ok, data_sram_rdata,
           wb_flush, wb_allow_in,
    output mem_allow_in, mem_to_wb_valid, mem_pc, mem_final_result, mem_rf_we,
           mem_rf_waddr, mem_ebus, mem_side, mem_has_ex, mem_bypass_bus
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data lane select and sign/zero extension for the MEM stage.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata_i[{addr_i, 3'b000} +: 8];
    lane_h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (mem_op_i)
      OP_LD_B:  result_o = {{24{lane_b[7]}}, lane_b};
      OP_LD_BU: result_o = {24'h0, lane_b};
      OP_LD_H:  result_o = {{16{lane_h[15]}}, lane_h};
      OP_LD_HU: result_o = {16'h0, lane_h};
      default:  result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data-SRAM response,
// aligns load data and drops responses orphaned by a WB flush. Define
// MEM_BYPASS_EN to drive mem_bypass_bus; otherwise it is tied to zero.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int SIDE_W = 97,
  parameter int DROP_W = 2
) (
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave bus
);

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  mem_state_e        state_q, state_d;
  logic              valid_q, valid_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]       rdata_q;
  logic [31:0]       pc_q, result_q;
  logic              rf_we_q, need_resp_q;
  logic [4:0]        waddr_q;
  logic [2:0]        mem_op_q;
  logic [EBUS_W-1:0] ebus_q;
  logic [SIDE_W-1:0] side_q;

  logic        resp_ok, ready_go, allow_in, load, load_need;
  logic        drop_inc, drop_dec, hold_capture;
  logic [31:0] load_src, aligned, final_result;
  logic        rf_we_out;

  // A response only belongs to the current instruction once all stale ones are gone
  assign resp_ok   = bus.data_sram_data_ok & (drop_cnt_q == '0);
  assign ready_go  = !need_resp_q | (state_q == ST_HOLD) | ((state_q == ST_WAIT) & resp_ok);
  assign allow_in  = !valid_q | (ready_go & bus.wb_allow_in);
  assign load      = bus.ex_to_mem_valid & allow_in & !bus.wb_flush;
  assign load_need = load & bus.ex_req_sent & (bus.ex_ebus == '0);

  assign drop_inc     = bus.wb_flush & (state_q == ST_WAIT) & !resp_ok;
  assign drop_dec     = bus.data_sram_data_ok & (drop_cnt_q != '0);
  assign hold_capture = (state_q == ST_WAIT) & resp_ok & !bus.wb_allow_in & !bus.wb_flush;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && !drop_dec && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end else if (drop_dec && !drop_inc) begin
      drop_cnt_d = drop_cnt_q - DROP_W'(1);
    end
    if (bus.wb_flush) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      if (allow_in) valid_d = bus.ex_to_mem_valid;
      case (state_q)
        ST_IDLE: if (load_need) state_d = ST_WAIT;
        ST_WAIT: begin
          if (resp_ok) begin
            if (bus.wb_allow_in) state_d = load_need ? ST_WAIT : ST_IDLE;
            else                 state_d = ST_HOLD;
          end
        end
        ST_HOLD: if (bus.wb_allow_in) state_d = load_need ? ST_WAIT : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      drop_cnt_q  <= '0;
      rdata_q     <= '0;
      pc_q        <= '0;
      result_q    <= '0;
      rf_we_q     <= 1'b0;
      need_resp_q <= 1'b0;
      waddr_q     <= '0;
      mem_op_q    <= '0;
      ebus_q      <= '0;
      side_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      drop_cnt_q <= drop_cnt_d;
      if (hold_capture) rdata_q <= bus.data_sram_rdata;
      if (load) begin
        pc_q        <= bus.ex_pc;
        result_q    <= bus.ex_result;
        rf_we_q     <= bus.ex_rf_we;
        need_resp_q <= bus.ex_req_sent & (bus.ex_ebus == '0);
        waddr_q     <= bus.ex_rf_waddr;
        mem_op_q    <= bus.ex_mem_op;
        ebus_q      <= bus.ex_ebus;
        side_q      <= bus.ex_side;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(drop_inc && !drop_dec && (drop_cnt_q == DROP_MAX)))
        else $error("mem_stage: stale-response counter overflow");
    end
  end
`endif

  // Live SRAM data is only trustworthy in the cycle data_ok arrives
  assign load_src = (state_q == ST_WAIT) ? bus.data_sram_rdata : rdata_q;

  load_align u_load_align (
    .mem_op_i (mem_op_q),
    .addr_i   (result_q[1:0]),
    .rdata_i  (load_src),
    .result_o (aligned)
  );

  assign final_result = is_load(mem_op_q) ? aligned : result_q;
  assign rf_we_out    = rf_we_q & valid_q & (ebus_q == '0);

  assign bus.mem_allow_in     = allow_in;
  assign bus.mem_to_wb_valid  = valid_q & ready_go;
  assign bus.mem_pc           = pc_q;
  assign bus.mem_final_result = final_result;
  assign bus.mem_rf_we        = rf_we_out;
  assign bus.mem_rf_waddr     = waddr_q;
  assign bus.mem_ebus         = ebus_q;
  assign bus.mem_side         = side_q;
  assign bus.mem_has_ex       = valid_q & ((ebus_q != '0) | side_q[SIDE_ERTN_BIT]);

`ifdef MEM_BYPASS_EN
  logic blocking;
  assign blocking           = valid_q & need_resp_q & !ready_go;
  assign bus.mem_bypass_bus = {blocking, rf_we_out, waddr_q, final_result};
`else
  assign bus.mem_bypass_bus = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed corner sequences, a load-alignment
// vector table and a randomized run scored against a transaction-level model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int SIDE_W = 97;
`ifdef MEM_BYPASS_EN
  localparam logic BYP_EN = 1'b1;
`else
  localparam logic BYP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_stage_if #(.SIDE_W(SIDE_W)) bus();

  mem_stage #(.SIDE_W(SIDE_W), .DROP_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic              exValid;
    logic [31:0]       pc;
    logic [31:0]       addr;
    logic              rfWe;
    logic [4:0]        waddr;
    logic [2:0]        op;
    logic              reqSent;
    logic [15:0]       ebus;
    logic [SIDE_W-1:0] side;
    logic              dataOk;
    logic [31:0]       rdata;
    logic              flush;
    logic              wbAllow;
  } stim_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] expResult;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic        rfWe;
    logic [4:0]  waddr;
    logic        hasEx;
    logic        checkResult;
  } wbexp_t;

  int checks = 0;
  int errors = 0;
  logic [2:0] ops [7] = '{OP_LD_B, OP_LD_H, OP_LD_W, OP_LD_BU, OP_LD_HU, OP_STORE, OP_NONE};

  function automatic stim_t idleStim();
    stim_t s;
    s.exValid = 1'b0; s.pc = '0; s.addr = '0; s.rfWe = 1'b0; s.waddr = '0;
    s.op = OP_NONE; s.reqSent = 1'b0; s.ebus = '0; s.side = '0;
    s.dataOk = 1'b0; s.rdata = '0; s.flush = 1'b0; s.wbAllow = 1'b1;
    return s;
  endfunction

  // Reference: architectural load semantics expressed as plain arithmetic
  function automatic logic [31:0] refResult(logic [2:0] op, logic [31:0] addr, logic [31:0] rdata);
    int unsigned b, h;
    b = (rdata >> (8 * addr[1:0])) % 256;
    h = (rdata >> (16 * addr[1])) % 65536;
    case (op)
      OP_LD_B:  return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      OP_LD_BU: return 32'(b);
      OP_LD_H:  return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      OP_LD_HU: return 32'(h);
      OP_LD_W:  return rdata;
      default:  return addr;
    endcase
  endfunction

  task automatic applyStimulus(input stim_t s);
    bus.ex_to_mem_valid   = s.exValid;
    bus.ex_pc             = s.pc;
    bus.ex_result         = s.addr;
    bus.ex_rf_we          = s.rfWe;
    bus.ex_rf_waddr       = s.waddr;
    bus.ex_mem_op         = s.op;
    bus.ex_req_sent       = s.reqSent;
    bus.ex_ebus           = s.ebus;
    bus.ex_side           = s.side;
    bus.data_sram_data_ok = s.dataOk;
    bus.data_sram_rdata   = s.rdata;
    bus.wb_flush          = s.flush;
    bus.wb_allow_in       = s.wbAllow;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t loadStim(logic [2:0] op, logic [31:0] addr, logic [31:0] pc, logic reqSent);
    stim_t s;
    s = idleStim();
    s.exValid = 1'b1; s.op = op; s.addr = addr; s.pc = pc;
    s.rfWe = 1'b1; s.waddr = 5'd3; s.reqSent = reqSent;
    return s;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t  s, cur;
    vec_t   vecs [9];
    wbexp_t e;
    wbexp_t expQ [$];
    bit     haveInstr, respPending;
    int     respDelay;
    logic [31:0] respData;

    // ---------------- reset state ----------------
    resetn = 1'b0;
    applyStimulus(idleStim());
    repeat (2) @(posedge clk);
    #1;
    settle();
    checkOutput("rstAllowIn", bus.mem_allow_in, 1);
    checkOutput("rstToWb", bus.mem_to_wb_valid, 0);
    checkOutput("rstResult", bus.mem_final_result, 0);
    checkOutput("rstPc", bus.mem_pc, 0);
    checkOutput("rstRfWe", bus.mem_rf_we, 0);
    checkOutput("rstBypass", bus.mem_bypass_bus, 0);
    checkOutput("rstHasEx", bus.mem_has_ex, 0);
    resetn = 1'b1;
    nextCycle();

    // ---------------- ALU pass-through ----------------
    s = loadStim(OP_NONE, 32'h0000_1234, 32'h1C00_0100, 1'b0);
    s.waddr = 5'd7;
    s.side[SIDE_W-1 -: 32] = 32'hA5A5_0F0F;
    applyStimulus(s);
    settle();
    checkOutput("aluAllowBefore", bus.mem_allow_in, 1);
    nextCycle();
    applyStimulus(idleStim());
    settle();
    checkOutput("aluToWb", bus.mem_to_wb_valid, 1);
    checkOutput("aluResult", bus.mem_final_result, 32'h0000_1234);
    checkOutput("aluPc", bus.mem_pc, 32'h1C00_0100);
    checkOutput("aluRfWe", bus.mem_rf_we, 1);
    checkOutput("aluWaddr", bus.mem_rf_waddr, 7);
    checkOutput("aluAllowIn", bus.mem_allow_in, 1);
    checkOutput("aluSide", 64'(bus.mem_side === s.side), 1);
    nextCycle();
    settle();
    checkOutput("aluGone", bus.mem_to_wb_valid, 0);
    nextCycle();

    // ---------------- ld.b with two wait cycles ----------------
    applyStimulus(loadStim(OP_LD_B, 32'h0000_1003, 32'h1C00_0200, 1'b1));
    nextCycle();
    applyStimulus(idleStim());
    for (int i = 0; i < 2; i++) begin
      settle();
      checkOutput("ldbWaitToWb", bus.mem_to_wb_valid, 0);
      checkOutput("ldbWaitAllow", bus.mem_allow_in, 0);
      checkOutput("ldbBlocking", bus.mem_bypass_bus[BYP_BLOCK_BIT], 64'(BYP_EN));
      nextCycle();
    end
    s = idleStim(); s.dataOk = 1'b1; s.rdata = 32'h80FF_0011;
    applyStimulus(s);
    settle();
    checkOutput("ldbToWb", bus.mem_to_wb_valid, 1);
    checkOutput("ldbResult", bus.mem_final_result, 32'hFFFF_FF80);
    checkOutput("ldbUnblocked", bus.mem_bypass_bus[BYP_BLOCK_BIT], 0);
    nextCycle();
    applyStimulus(idleStim());
    settle();
    checkOutput("ldbGone", bus.mem_to_wb_valid, 0);
    nextCycle();

    // ---------------- load alignment table ----------------
    vecs[0] = '{OP_LD_B,  32'h0000_1003, 32'h80FF_0011, 32'hFFFF_FF80};
    vecs[1] = '{OP_LD_B,  32'h0000_1000, 32'h80FF_0011, 32'h0000_0011};
    vecs[2] = '{OP_LD_BU, 32'h0000_1002, 32'h80FF_0011, 32'h0000_00FF};
    vecs[3] = '{OP_LD_B,  32'h0000_1002, 32'h80FF_0011, 32'hFFFF_FFFF};
    vecs[4] = '{OP_LD_H,  32'h0000_1000, 32'hBEEF_1234, 32'h0000_1234};
    vecs[5] = '{OP_LD_H,  32'h0000_1002, 32'hBEEF_1234, 32'hFFFF_BEEF};
    vecs[6] = '{OP_LD_HU, 32'h0000_1002, 32'hBEEF_1234, 32'h0000_BEEF};
    vecs[7] = '{OP_LD_W,  32'h0000_1000, 32'hBEEF_1234, 32'hBEEF_1234};
    vecs[8] = '{OP_LD_BU, 32'h0000_1001, 32'h1234_5678, 32'h0000_0056};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(loadStim(vecs[i].op, vecs[i].addr, 32'h1C00_1000 + 32'(4 * i), 1'b1));
      nextCycle();
      s = idleStim(); s.dataOk = 1'b1; s.rdata = vecs[i].rdata;
      applyStimulus(s);
      settle();
      checkOutput($sformatf("vecToWb%0d", i), bus.mem_to_wb_valid, 1);
      checkOutput($sformatf("vecResult%0d", i), bus.mem_final_result, vecs[i].expResult);
      nextCycle();
      applyStimulus(idleStim());
      nextCycle();
    end

    // ---------------- ld.hu held while WB stalls ----------------
    applyStimulus(loadStim(OP_LD_HU, 32'h0000_2002, 32'h1C00_0300, 1'b1));
    nextCycle();
    s = idleStim(); s.dataOk = 1'b1; s.rdata = 32'hBEEF_1234; s.wbAllow = 1'b0;
    applyStimulus(s);
    settle();
    checkOutput("holdFirstToWb", bus.mem_to_wb_valid, 1);
    checkOutput("holdFirstResult", bus.mem_final_result, 32'h0000_BEEF);
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      s = idleStim(); s.rdata = 32'h5555_AAAA; s.wbAllow = (i == 1);
      applyStimulus(s);
      settle();
      checkOutput("holdToWb", bus.mem_to_wb_valid, 1);
      checkOutput("holdResult", bus.mem_final_result, 32'h0000_BEEF);
      checkOutput("holdAllowIn", bus.mem_allow_in, 64'(i == 1));
      nextCycle();
    end
    applyStimulus(idleStim());
    settle();
    checkOutput("holdGone", bus.mem_to_wb_valid, 0);
    nextCycle();

    // ---------------- flush in WAIT, stale response dropped ----------------
    applyStimulus(loadStim(OP_LD_W, 32'h0000_3000, 32'h1C00_0400, 1'b1));
    nextCycle();
    s = idleStim(); s.flush = 1'b1;
    applyStimulus(s);
    nextCycle();
    applyStimulus(loadStim(OP_LD_W, 32'h0000_3004, 32'h1C00_0404, 1'b1));
    settle();
    checkOutput("flushToWb", bus.mem_to_wb_valid, 0);
    checkOutput("flushAllowIn", bus.mem_allow_in, 1);
    nextCycle();
    applyStimulus(idleStim());
    settle();
    checkOutput("flushWaitToWb", bus.mem_to_wb_valid, 0);
    nextCycle();
    s = idleStim(); s.dataOk = 1'b1; s.rdata = 32'hDEAD_BEEF;
    applyStimulus(s);
    settle();
    checkOutput("staleToWb", bus.mem_to_wb_valid, 0);
    checkOutput("staleBlocking", bus.mem_bypass_bus[BYP_BLOCK_BIT], 64'(BYP_EN));
    nextCycle();
    s = idleStim(); s.dataOk = 1'b1; s.rdata = 32'h1234_5678;
    applyStimulus(s);
    settle();
    checkOutput("freshToWb", bus.mem_to_wb_valid, 1);
    checkOutput("freshResult", bus.mem_final_result, 32'h1234_5678);
    checkOutput("freshPc", bus.mem_pc, 32'h1C00_0404);
    nextCycle();
    applyStimulus(idleStim());
    nextCycle();

    // ---------------- ALE exception, no request ----------------
    s = loadStim(OP_LD_W, 32'h0000_4001, 32'h1C00_0500, 1'b0);
    s.ebus = 16'(1 << EBUS_ALE);
    applyStimulus(s);
    nextCycle();
    applyStimulus(idleStim());
    settle();
    checkOutput("aleToWb", bus.mem_to_wb_valid, 1);
    checkOutput("aleHasEx", bus.mem_has_ex, 1);
    checkOutput("aleRfWe", bus.mem_rf_we, 0);
    checkOutput("aleEbus", bus.mem_ebus, 16'(1 << EBUS_ALE));
    nextCycle();

    // ---------------- reset while waiting with a stale response owed ----------------
    applyStimulus(loadStim(OP_LD_W, 32'h0000_5000, 32'h1C00_0600, 1'b1));
    nextCycle();
    s = idleStim(); s.flush = 1'b1;
    applyStimulus(s);
    nextCycle();
    applyStimulus(loadStim(OP_LD_W, 32'h0000_5004, 32'h1C00_0604, 1'b1));
    nextCycle();
    applyStimulus(idleStim());
    resetn = 1'b0;
    settle();
    checkOutput("rstWaitToWb", bus.mem_to_wb_valid, 0);
    checkOutput("rstWaitAllow", bus.mem_allow_in, 1);
    checkOutput("rstWaitResult", bus.mem_final_result, 0);
    checkOutput("rstWaitPc", bus.mem_pc, 0);
    checkOutput("rstWaitBypass", bus.mem_bypass_bus, 0);
    nextCycle();
    resetn = 1'b1;
    nextCycle();
    applyStimulus(loadStim(OP_LD_W, 32'h0000_6000, 32'h1C00_0700, 1'b1));
    nextCycle();
    s = idleStim(); s.dataOk = 1'b1; s.rdata = 32'hCAFE_F00D;
    applyStimulus(s);
    settle();
    checkOutput("postRstToWb", bus.mem_to_wb_valid, 1);
    checkOutput("postRstResult", bus.mem_final_result, 32'hCAFE_F00D);
    nextCycle();
    applyStimulus(idleStim());
    nextCycle();

    // ---------------- randomized traffic against the transaction model ----------------
    haveInstr   = 1'b0;
    respPending = 1'b0;
    respDelay   = 0;
    respData    = '0;
    cur         = idleStim();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!haveInstr && cyc < 360 && ($urandom % 4 != 0)) begin
        cur = idleStim();
        cur.exValid = 1'b1;
        cur.pc      = $urandom;
        cur.addr    = $urandom;
        cur.op      = ops[$urandom_range(0, 6)];
        cur.waddr   = 5'($urandom_range(1, 31));
        cur.rfWe    = (cur.op != OP_STORE) && ($urandom % 4 != 0);
        cur.ebus    = ($urandom % 8 == 0) ? 16'(1 << EBUS_ALE) : 16'h0;
        cur.reqSent = (cur.op != OP_NONE) && (cur.ebus == 16'h0);
        haveInstr   = 1'b1;
      end
      s = haveInstr ? cur : idleStim();
      s.exValid = haveInstr;
      s.dataOk  = respPending && (respDelay == 0);
      s.rdata   = s.dataOk ? respData : $urandom;
      s.wbAllow = ($urandom % 4 != 0);
      applyStimulus(s);
      settle();
      if (bus.mem_to_wb_valid && s.wbAllow) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rndSpurious: got retire of pc %0h expected no instruction", bus.mem_pc);
        end else begin
          e = expQ.pop_front();
          checkOutput("rndPc", bus.mem_pc, e.pc);
          checkOutput("rndRfWe", bus.mem_rf_we, e.rfWe);
          checkOutput("rndWaddr", bus.mem_rf_waddr, e.waddr);
          checkOutput("rndHasEx", bus.mem_has_ex, e.hasEx);
          if (e.checkResult) checkOutput("rndResult", bus.mem_final_result, e.result);
        end
      end
      if (s.dataOk) respPending = 1'b0;
      else if (respPending) respDelay--;
      if (haveInstr && bus.mem_allow_in) begin
        haveInstr     = 1'b0;
        e.pc          = cur.pc;
        e.rfWe        = cur.rfWe && (cur.ebus == 16'h0);
        e.waddr       = cur.waddr;
        e.hasEx       = (cur.ebus != 16'h0);
        e.checkResult = !e.hasEx;
        if (cur.reqSent) begin
          respPending = 1'b1;
          respDelay   = $urandom_range(0, 2);
          respData    = $urandom;
          e.result    = refResult(cur.op, cur.addr, respData);
        end else begin
          e.result    = refResult(cur.op, cur.addr, 32'h0);
        end
        expQ.push_back(e);
      end
      nextCycle();
    end
    checkOutput("rndDrained", 64'(expQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
